// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter: up to NUM_ALUS eligible threads win each cycle and
// their bundles are registered into per-ALU slot registers.
module alu_issue_arbiter #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_ALUS    = 3,
  parameter int TID_W       = 2,
  parameter int PAYLOAD_W   = 140,
  parameter int CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_THREADS-1:0]         req_valid,
  input  logic [NUM_THREADS*PAYLOAD_W-1:0] req_payload,
  output logic [NUM_THREADS-1:0]         req_ready,
  input  logic [NUM_THREADS-1:0]         thread_flush,
  input  logic                           alu_stall,
  output logic [NUM_ALUS-1:0]            alu_valid,
  output logic [NUM_ALUS*TID_W-1:0]      alu_tid,
  output logic [NUM_ALUS*PAYLOAD_W-1:0]  alu_payload,
  output logic [NUM_THREADS*CNT_W-1:0]   issue_cnt
);

  localparam int SLOT_CW = $clog2(NUM_ALUS + 1);
  localparam logic [SLOT_CW-1:0] SLOTS = SLOT_CW'(NUM_ALUS);

  logic [TID_W-1:0]     rr_q, rr_d;
  logic [NUM_ALUS-1:0]  valid_q;
  logic [TID_W-1:0]     tid_q   [NUM_ALUS];
  logic [PAYLOAD_W-1:0] pl_q    [NUM_ALUS];
  logic [CNT_W-1:0]     cnt_q   [NUM_THREADS];

  logic [NUM_THREADS-1:0] elig;
  logic [NUM_THREADS-1:0] grant;
  logic [NUM_ALUS-1:0]    slot_vld;
  logic [TID_W-1:0]       slot_tid [NUM_ALUS];
  logic [PAYLOAD_W-1:0]   slot_pl  [NUM_ALUS];
  logic [TID_W-1:0]       scan_tid;
  logic [SLOT_CW-1:0]     n_grant;

  assign elig = req_valid & ~thread_flush & {NUM_THREADS{~alu_stall}};

  // Thread count is a power of two, so the TID_W-bit add wraps the scan for free.
  always_comb begin
    grant    = '0;
    slot_vld = '0;
    for (int k = 0; k < NUM_ALUS; k++) slot_tid[k] = '0;
    rr_d     = rr_q;
    n_grant  = '0;
    scan_tid = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      scan_tid = rr_q + TID_W'(i);
      if (elig[scan_tid] && (n_grant < SLOTS)) begin
        grant[scan_tid]   = 1'b1;
        slot_vld[n_grant] = 1'b1;
        slot_tid[n_grant] = scan_tid;
        rr_d              = scan_tid + TID_W'(1);
        n_grant           = n_grant + SLOT_CW'(1);
      end
    end
  end

  assign req_ready = rst ? '0 : grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q    <= '0;
      valid_q <= '0;
    end else if (!alu_stall) begin
      rr_q    <= rr_d;
      valid_q <= slot_vld;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ALUS; gi++) begin : g_slot
      assign slot_pl[gi] = req_payload[slot_tid[gi]*PAYLOAD_W +: PAYLOAD_W];

      // Ungranted slots keep tid/payload; only the valid bit drops.
      always_ff @(posedge clk) begin
        if (rst) begin
          tid_q[gi] <= '0;
          pl_q[gi]  <= '0;
        end else if (!alu_stall && slot_vld[gi]) begin
          tid_q[gi] <= slot_tid[gi];
          pl_q[gi]  <= slot_pl[gi];
        end
      end

      assign alu_valid[gi]                         = valid_q[gi];
      assign alu_tid[gi*TID_W +: TID_W]            = tid_q[gi];
      assign alu_payload[gi*PAYLOAD_W +: PAYLOAD_W] = pl_q[gi];
    end

    for (gi = 0; gi < NUM_THREADS; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q[gi] <= '0;
        end else if (grant[gi] && (cnt_q[gi] != '1)) begin
          cnt_q[gi] <= cnt_q[gi] + CNT_W'(1);
        end
      end
      assign issue_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then random traffic and a saturation run.
module tb_alu_issue_arbiter;
  localparam int NT = 4, NA = 3, TW = 2, PW = 140, CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NT-1:0]     req_valid, req_ready, thread_flush;
  logic [NT*PW-1:0]  req_payload;
  logic              alu_stall;
  logic [NA-1:0]     alu_valid;
  logic [NA*TW-1:0]  alu_tid;
  logic [NA*PW-1:0]  alu_payload;
  logic [NT*CW-1:0]  issue_cnt;

  alu_issue_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_payload(req_payload),
    .req_ready(req_ready), .thread_flush(thread_flush), .alu_stall(alu_stall),
    .alu_valid(alu_valid), .alu_tid(alu_tid), .alu_payload(alu_payload),
    .issue_cnt(issue_cnt)
  );

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;

  // Reference model state
  int            m_rr;
  bit            m_v   [NA];
  int            m_tid [NA];
  logic [PW-1:0] m_pl  [NA];
  int            m_cnt [NT];
  int            m_order[$];

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] rand_pl();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[PW-1:0];
  endfunction

  task automatic rand_payloads();
    for (int t = 0; t < NT; t++) req_payload[t*PW +: PW] = rand_pl();
  endtask

  task automatic model_reset();
    m_rr = 0;
    for (int k = 0; k < NA; k++) begin m_v[k] = 0; m_tid[k] = 0; m_pl[k] = '0; end
    for (int t = 0; t < NT; t++) m_cnt[t] = 0;
  endtask

  // Compare at negedge, then advance the model across the following posedge.
  task automatic step();
    logic [NT-1:0] g;
    @(negedge clk);
    m_order.delete();
    g = '0;
    if (!rst && !alu_stall) begin
      for (int i = 0; i < NT; i++) begin
        int t;
        t = (m_rr + i) % NT;
        if (req_valid[t] && !thread_flush[t] && m_order.size() < NA) begin
          m_order.push_back(t);
          g[t] = 1'b1;
        end
      end
    end
    chk("req_ready", PW'(req_ready), PW'(g));
    for (int k = 0; k < NA; k++) begin
      chk($sformatf("alu_valid[%0d]", k), PW'(alu_valid[k]), PW'(m_v[k]));
      chk($sformatf("alu_tid[%0d]", k), PW'(alu_tid[k*TW +: TW]), PW'(m_tid[k]));
      chk($sformatf("alu_payload[%0d]", k), alu_payload[k*PW +: PW], m_pl[k]);
    end
    for (int t = 0; t < NT; t++)
      chk($sformatf("issue_cnt[%0d]", t), PW'(issue_cnt[t*CW +: CW]), PW'(m_cnt[t]));
    if (verbose)
      $display("t=%0t rst=%0b v=%b fl=%b st=%0b ready=%b alu_v=%b tid=%h",
               $time, rst, req_valid, thread_flush, alu_stall, req_ready, alu_valid, alu_tid);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (!alu_stall) begin
      for (int k = 0; k < NA; k++) begin
        if (k < m_order.size()) begin
          m_v[k]   = 1;
          m_tid[k] = m_order[k];
          m_pl[k]  = req_payload[m_order[k]*PW +: PW];
        end else begin
          m_v[k] = 0;
        end
      end
      if (m_order.size() > 0) m_rr = (m_order[m_order.size()-1] + 1) % NT;
      foreach (m_order[i]) if (m_cnt[m_order[i]] < 65535) m_cnt[m_order[i]]++;
    end
    #1;
  endtask

  initial begin
    logic [PW-1:0] pl2;
    logic [4:0] rd;
    model_reset();
    rst = 1'b1; req_valid = '0; thread_flush = '0; alu_stall = 1'b0; req_payload = '0;
    #1;
    step(); step();
    chk("reset_alu_valid", PW'(alu_valid), PW'(3'b000));
    chk("reset_issue_cnt", PW'(issue_cnt), PW'(0));

    // All four threads requesting from rr=0
    rst = 1'b0; req_valid = 4'b1111; rand_payloads(); #1;
    chk("c1_ready", PW'(req_ready), PW'(4'b0111));
    step();
    chk("c1_alu_valid", PW'(alu_valid), PW'(3'b111));
    chk("c1_tids", PW'(alu_tid), PW'({2'd2, 2'd1, 2'd0}));
    rand_payloads(); #1;
    chk("c2_ready", PW'(req_ready), PW'(4'b1011));
    step();
    chk("c2_tids", PW'(alu_tid), PW'({2'd1, 2'd0, 2'd3}));

    // Single requester, thread 2, rr=2
    rd  = 5'($urandom);
    pl2 = {$urandom, $urandom, 32'd5, 32'd7, rd, 7'd28};
    req_valid = 4'b0100; req_payload[2*PW +: PW] = pl2; #1;
    chk("single_ready", PW'(req_ready), PW'(4'b0100));
    step();
    chk("single_alu_valid", PW'(alu_valid), PW'(3'b001));
    chk("single_tid0", PW'(alu_tid[1:0]), PW'(2'd2));
    chk("single_payload", alu_payload[PW-1:0], pl2);
    req_valid = 4'b1111; rand_payloads(); #1;
    chk("after_single_ready", PW'(req_ready), PW'(4'b1011));
    step();

    // Stall for three cycles with everything requesting
    alu_stall = 1'b1;
    repeat (3) begin
      rand_payloads(); #1;
      chk("stall_ready", PW'(req_ready), PW'(4'b0000));
      step();
      chk("stall_alu_valid", PW'(alu_valid), PW'(3'b111));
      chk("stall_tids", PW'(alu_tid), PW'({2'd1, 2'd0, 2'd3}));
    end
    alu_stall = 1'b0; #1;
    chk("unstall_ready", PW'(req_ready), PW'(4'b1101));
    step();

    // Bring rr to 0, then flush thread 1
    req_valid = 4'b1000; rand_payloads(); step();
    req_valid = 4'b1111; thread_flush = 4'b0010; rand_payloads(); #1;
    chk("flush_ready", PW'(req_ready), PW'(4'b1101));
    step();
    chk("flush_tids", PW'(alu_tid), PW'({2'd3, 2'd2, 2'd0}));
    thread_flush = '0;

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      req_valid    = 4'($urandom);
      thread_flush = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      alu_stall    = ($urandom_range(0, 4) == 0);
      rst          = ($urandom_range(0, 49) == 0);
      rand_payloads();
      step();
    end
    rst = 1'b0; alu_stall = 1'b0; thread_flush = '0;

    // Reset in the middle of full issue
    req_valid = 4'b1111; rand_payloads(); step();
    rand_payloads(); step();
    chk("pre_rst_alu_valid", PW'(alu_valid), PW'(3'b111));
    rst = 1'b1; #1;
    chk("rst_ready", PW'(req_ready), PW'(4'b0000));
    step();
    chk("post_rst_alu_valid", PW'(alu_valid), PW'(3'b000));
    chk("post_rst_issue_cnt", PW'(issue_cnt), PW'(0));
    rst = 1'b0; rand_payloads(); #1;
    chk("post_rst_ready", PW'(req_ready), PW'(4'b0111));
    step();

    // Saturate thread 0's counter
    verbose = 1'b0;
    req_valid = 4'b0001;
    for (int c = 0; c < 65540; c++) begin
      if ((c % 4096) == 0) rand_payloads();
      step();
    end
    chk("sat_cnt0", PW'(issue_cnt[CW-1:0]), PW'(16'hFFFF));
    step(); step();
    chk("sat_cnt0_hold", PW'(issue_cnt[CW-1:0]), PW'(16'hFFFF));
    verbose = 1'b1;
    req_valid = '0; step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
